imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequencer and arbiter for the 256-byte, byte-wide instruction memory. It serves 32-bit fetch requests from the CPU by issuing four sequential byte reads and assembling a big-endian word. It also accepts byte writes from a program loader, with loader priority. It sits between the fetch stage / boot loader and a single-port synchronous byte RAM.

## Interface
- ADDR_W, 8, byte-address width of the memory; memory depth is 2^ADDR_W bytes
- WORD_BYTES, 4, bytes per instruction; fixed, not for override
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- fetch_req  in  1  fetch request; held until accepted
- fetch_addr  in  32  byte address; only [ADDR_W-1:0] used, upper bits ignored
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready
- fetch_valid  out  1  one-cycle pulse; instruction valid
- fetch_err  out  1  one-cycle pulse; misaligned request (fetch_addr[1:0] != 0)
- instruction  out  32  assembled word; holds until next successful fetch
- load_valid  in  1  loader byte-write request
- load_addr  in  ADDR_W  loader byte address
- load_data  in  8  loader byte
- load_ready  out  1  write accepted when load_valid && load_ready
- mem_addr  out  ADDR_W  RAM byte address
- mem_re  out  1  RAM read enable; data returns on mem_rdata the following cycle
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte, 1-cycle latency
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE
  - READ: counter k = 0..3; issues byte k and captures byte k-1
  - LAST: captures byte 3
  - DONE: pulses fetch_valid
  - WRITE: one cycle
  - ERR: pulses fetch_err
- IDLE arbitration:
  - load_ready = (state==IDLE) && !reset.
  - fetch_ready = (state==IDLE) && !load_valid && !reset.
  - Loader has strict priority; a pending fetch waits with no starvation guarantee, because loading is boot-time only.
- Load accept -> WRITE: mem_addr=load_addr, mem_wdata=load_data, mem_we=1 for exactly one cycle -> IDLE.
- Aligned fetch accept:
  - Latch base = fetch_addr[ADDR_W-1:0] -> READ (k=0).
  - READ drives mem_addr=base+k and mem_re=1. For k≥1 it captures mem_rdata as byte k-1. After k=3 -> LAST.
  - LAST: mem_re=0; capture byte 3 -> DONE.
  - DONE: fetch_valid=1, instruction updated; -> IDLE.
- Byte order:
  - Big-endian: byte at base -> instruction[31:24], base+3 -> [7:0].
  - Address arithmetic is mod 2^ADDR_W. With aligned bases, no word crosses the top of memory.
- Misaligned fetch accept -> ERR: no RAM access, fetch_err=1, instruction unchanged; -> IDLE.
- Partial bytes are assembled in a staging register. instruction is written only in DONE, so it never shows a partial word.
- mem_we and mem_re are never high together.

## Timing
- Aligned fetch accepted in cycle 0:
  - mem_addr = base..base+3 in cycles 1-4.
  - Bytes captured at the end of cycles 2-5.
  - fetch_valid in cycle 6.
  - IDLE again in cycle 7; fetch_ready may be high in cycle 7.
  - Throughput is one fetch per 7 cycles.
- Load accepted in cycle 0: write in cycle 1; load_ready high again in cycle 2.
- Misaligned fetch accepted in cycle 0: fetch_err in cycle 1; IDLE in cycle 2.
- Requests arriving while busy are not accepted (ready=0). The requester holds them.
- Reset values, forced asynchronously:
  - state IDLE, k=0
  - fetch_valid=0, fetch_err=0, instruction=0
  - mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, busy=0
  - fetch_ready=0, load_ready=0 while reset is high
- Reset mid-fetch discards staged bytes; no fetch_valid. Reset during WRITE drops mem_we immediately.

## Structure
- Package imem_pkg:
  - state enum (IDLE, READ, LAST, DONE, WRITE, ERR)
  - WORD_BYTES=4
  - ADDR_W default
  - BYTE_W=8
- Sub-module imem_byte_assembler: 4-byte staging shift register, big-endian packing, capture enable and clear. The controller instantiates it once.

## Test plan
- RAM 0x00..0x03 = 0x8C,0x01,0x00,0x04; fetch 0x00 -> fetch_valid in cycle 6, instruction=0x8C010004; mem_addr sequence 0,1,2,3.
- Fetch 0xFC with RAM FC..FF = 0xDE,0xAD,0xBE,0xEF -> instruction=0xDEADBEEF. Fetch 0x1FC (upper bits ignored) -> same word.
- Fetch 0x05 -> fetch_err pulse cycle 1, no mem_re, instruction keeps its prior value.
- load_valid and fetch_req raised together -> write (addr 0x10, data 0x55) in cycle 1 first. Fetch accepted in cycle 2. Reading 0x10 then returns 0x55 in [31:24].
- Reset asserted in cycle 3 of a fetch -> outputs at reset values immediately, no fetch_valid. After release, a new fetch completes normally.
- Back-to-back fetches 0x00, 0x04 with fetch_req held -> second accepted in cycle 7, valid in cycle 13; busy never low while in READ.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory
// fetch controller and its byte assembler.
package imem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int WORD_BYTES = 4;
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = WORD_BYTES * BYTE_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_LAST  = 3'd2,
      ST_DONE  = 3'd3,
      ST_WRITE = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch, loader and RAM-side signals of the instruction-memory controller.
// The controller is the slave; the CPU, boot loader and RAM form the master.
interface imem_fetch_ctrl_if
   import imem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic                fetch_req;
   logic [31:0]         fetch_addr;
   logic                fetch_ready;
   logic                fetch_valid;
   logic                fetch_err;
   logic [WORD_W-1:0]   instruction;

   logic                load_valid;
   logic [ADDR_W-1:0]   load_addr;
   logic [BYTE_W-1:0]   load_data;
   logic                load_ready;

   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_re;
   logic                mem_we;
   logic [BYTE_W-1:0]   mem_wdata;
   logic [BYTE_W-1:0]   mem_rdata;

   logic                busy;

   modport master (
      output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, fetch_valid, fetch_err, instruction, load_ready,
             mem_addr, mem_re, mem_we, mem_wdata, busy
   );

   modport slave (
      input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, fetch_valid, fetch_err, instruction, load_ready,
             mem_addr, mem_re, mem_we, mem_wdata, busy
   );

endinterface

// File: rtl/imem_fetch_ctrl_byte_assembler.sv
// Staging shift register that packs RAM bytes big-endian: the first byte
// captured after a clear ends up in the most significant position.
module imem_byte_assembler
   import imem_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              capture,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_next
);

   logic [WORD_W-1:0] stage_r;
   logic              unused_msb_s;

   // The complete word including the byte arriving this cycle, so the
   // controller can publish it without waiting for the shift to land.
   assign word_next    = {stage_r[WORD_W-BYTE_W-1:0], byte_in};
   assign unused_msb_s = ^stage_r[WORD_W-1:WORD_W-BYTE_W];

   // Staging register: cleared at fetch start, shifts one byte per capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_r <= {WORD_W{1'b0}};
      end else if (clear) begin
         stage_r <= {WORD_W{1'b0}};
      end else if (capture) begin
         stage_r <= word_next;
      end else begin
         stage_r <= stage_r;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Sequencer/arbiter for a byte-wide synchronous instruction RAM: loader byte
// writes take priority, CPU fetches become four byte reads packed big-endian.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic             clock,
   input  logic             reset,
   imem_fetch_ctrl_if.slave bus
);

   localparam logic [1:0] K_LAST = 2'(WORD_BYTES - 1);

   state_t              state_r, state_s;
   logic [1:0]          k_r, k_s;
   logic [ADDR_W-1:0]   base_r, base_s;
   logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
   logic                mem_re_r, mem_re_s;
   logic                mem_we_r, mem_we_s;
   logic [BYTE_W-1:0]   mem_wdata_r, mem_wdata_s;
   logic                fetch_valid_r, fetch_valid_s;
   logic                fetch_err_r, fetch_err_s;
   logic [WORD_W-1:0]   instruction_r;
   logic                busy_r;
   logic                stage_clear_s;
   logic                stage_capture_s;
   logic [WORD_W-1:0]   word_next_s;
   logic                unused_addr_s;

   // Only the low ADDR_W bits of the fetch address select a byte.
   assign unused_addr_s = ^bus.fetch_addr[31:ADDR_W];

   assign bus.load_ready  = (state_r == ST_IDLE) && !reset;
   assign bus.fetch_ready = (state_r == ST_IDLE) && !bus.load_valid && !reset;

   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_re      = mem_re_r;
   assign bus.mem_we      = mem_we_r;
   assign bus.mem_wdata   = mem_wdata_r;
   assign bus.fetch_valid = fetch_valid_r;
   assign bus.fetch_err   = fetch_err_r;
   assign bus.instruction = instruction_r;
   assign bus.busy        = busy_r;

   imem_byte_assembler u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (stage_clear_s),
      .capture   (stage_capture_s),
      .byte_in   (bus.mem_rdata),
      .word_next (word_next_s)
   );

   // Next-state logic; RAM strobes and pulses are computed one cycle ahead
   // so they leave the block straight from flops.
   always_comb begin
      state_s         = state_r;
      k_s             = k_r;
      base_s          = base_r;
      mem_addr_s      = {ADDR_W{1'b0}};
      mem_re_s        = 1'b0;
      mem_we_s        = 1'b0;
      mem_wdata_s     = {BYTE_W{1'b0}};
      fetch_valid_s   = 1'b0;
      fetch_err_s     = 1'b0;
      stage_clear_s   = 1'b0;
      stage_capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.load_valid) begin
               state_s     = ST_WRITE;
               mem_we_s    = 1'b1;
               mem_addr_s  = bus.load_addr;
               mem_wdata_s = bus.load_data;
            end else if (bus.fetch_req) begin
               if (word_aligned(bus.fetch_addr[1:0])) begin
                  state_s       = ST_READ;
                  k_s           = 2'd0;
                  base_s        = bus.fetch_addr[ADDR_W-1:0];
                  mem_addr_s    = bus.fetch_addr[ADDR_W-1:0];
                  mem_re_s      = 1'b1;
                  stage_clear_s = 1'b1;
               end else begin
                  state_s     = ST_ERR;
                  fetch_err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            // Data for the read issued last cycle is on mem_rdata now.
            stage_capture_s = (k_r != 2'd0);
            if (k_r == K_LAST) begin
               state_s = ST_LAST;
               k_s     = 2'd0;
            end else begin
               k_s        = k_r + 2'd1;
               mem_addr_s = base_r + ADDR_W'(k_r + 2'd1);
               mem_re_s   = 1'b1;
            end
         end
         ST_LAST: begin
            stage_capture_s = 1'b1;
            fetch_valid_s   = 1'b1;
            state_s         = ST_DONE;
         end
         ST_DONE:  state_s = ST_IDLE;
         ST_WRITE: state_s = ST_IDLE;
         ST_ERR:   state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State, address counter and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         k_r           <= 2'd0;
         base_r        <= {ADDR_W{1'b0}};
         mem_addr_r    <= {ADDR_W{1'b0}};
         mem_re_r      <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_wdata_r   <= {BYTE_W{1'b0}};
         fetch_valid_r <= 1'b0;
         fetch_err_r   <= 1'b0;
         instruction_r <= {WORD_W{1'b0}};
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         k_r           <= k_s;
         base_r        <= base_s;
         mem_addr_r    <= mem_addr_s;
         mem_re_r      <= mem_re_s;
         mem_we_r      <= mem_we_s;
         mem_wdata_r   <= mem_wdata_s;
         fetch_valid_r <= fetch_valid_s;
         fetch_err_r   <= fetch_err_s;
         busy_r        <= (state_s != ST_IDLE);
         // Publish the finished word together with fetch_valid, never a partial one.
         if (state_r == ST_LAST) begin
            instruction_r <= word_next_s;
         end else begin
            instruction_r <= instruction_r;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a memory model.
module tb_imem_fetch_ctrl;
   import imem_pkg::*;

   logic clock = 1'b0;
   logic reset;

   imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

   imem_fetch_ctrl #(.ADDR_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [7:0]  ram    [256];
   logic [7:0]  shadow [256];
   logic [31:0] model_instr;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Synchronous byte RAM with one-cycle read latency.
   always @(posedge clock) begin
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Big-endian word as seen through the bench's own view of memory contents.
   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [7:0] b0, b1, b2, b3;
      b0 = a[7:0];
      b1 = b0 + 8'd1;
      b2 = b0 + 8'd2;
      b3 = b0 + 8'd3;
      return {shadow[b0], shadow[b1], shadow[b2], shadow[b3]};
   endfunction

   // Issue a fetch and watch cycles 1..8 after acceptance; starts and ends at a negedge.
   task automatic run_fetch(input logic [31:0] a, input bit exp_err,
                            input logic [31:0] exp_word, input string tag);
      int w, vcyc, ecyc, nval, nerr, nre, both;
      logic [31:0] addrs, word_at_valid;
      logic [7:0]  b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      w = 0;
      while (!bus.fetch_ready && w < 40) begin
         @(negedge clock);
         w++;
      end
      check({tag, " accept"}, 32'(bus.fetch_ready), 32'd1);
      if (!bus.fetch_ready) begin
         bus.fetch_req = 1'b0;
         return;
      end
      vcyc = -1; ecyc = -1; nval = 0; nerr = 0; nre = 0; both = 0;
      addrs = 32'd0; word_at_valid = 32'd0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (bus.mem_re) begin
            addrs = {addrs[23:0], bus.mem_addr};
            nre++;
         end
         if (bus.mem_re && bus.mem_we) both++;
         if (bus.fetch_valid) begin
            nval++;
            if (vcyc < 0) vcyc = c;
            word_at_valid = bus.instruction;
         end
         if (bus.fetch_err) begin
            nerr++;
            if (ecyc < 0) ecyc = c;
         end
         if (c == 1) bus.fetch_req = 1'b0;
      end
      check({tag, " valid cycle"}, 32'(vcyc), exp_err ? 32'hFFFF_FFFF : 32'd6);
      check({tag, " valid pulses"}, 32'(nval), exp_err ? 32'd0 : 32'd1);
      check({tag, " err cycle"}, 32'(ecyc), exp_err ? 32'd1 : 32'hFFFF_FFFF);
      check({tag, " err pulses"}, 32'(nerr), exp_err ? 32'd1 : 32'd0);
      check({tag, " read count"}, 32'(nre), exp_err ? 32'd0 : 32'd4);
      check({tag, " re&we overlap"}, 32'(both), 32'd0);
      check({tag, " instruction"}, bus.instruction, exp_word);
      if (!exp_err) begin
         b0 = a[7:0];
         check({tag, " addr seq"}, addrs, {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
         check({tag, " word at valid"}, word_at_valid, exp_word);
      end
      model_instr = exp_word;
   endtask

   task automatic run_load(input logic [7:0] a, input logic [7:0] d, input string tag);
      int w;
      bus.load_valid = 1'b1;
      bus.load_addr  = a;
      bus.load_data  = d;
      w = 0;
      while (!bus.load_ready && w < 40) begin
         @(negedge clock);
         w++;
      end
      check({tag, " accept"}, 32'(bus.load_ready), 32'd1);
      if (!bus.load_ready) begin
         bus.load_valid = 1'b0;
         return;
      end
      @(negedge clock);
      check({tag, " we"}, {30'd0, bus.mem_we, bus.mem_re}, 32'd2);
      check({tag, " addr/data"}, {16'd0, bus.mem_addr, bus.mem_wdata}, {16'd0, a, d});
      check({tag, " ready in write"}, 32'(bus.load_ready), 32'd0);
      bus.load_valid = 1'b0;
      @(negedge clock);
      check({tag, " we dropped"}, 32'(bus.mem_we), 32'd0);
      check({tag, " ready again"}, 32'(bus.load_ready), 32'd1);
      shadow[a] = d;
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          err;
      logic [31:0] word;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int          rc, v1, v2, nvalid, bad_busy;
      logic [31:0] w1, w2, a;
      logic [7:0]  la, ld;

      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 32'd0;
      bus.load_valid = 1'b0;
      bus.load_addr  = 8'd0;
      bus.load_data  = 8'd0;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
      ram[8'h00] = 8'h8C; ram[8'h01] = 8'h01; ram[8'h02] = 8'h00; ram[8'h03] = 8'h04;
      ram[8'hFC] = 8'hDE; ram[8'hFD] = 8'hAD; ram[8'hFE] = 8'hBE; ram[8'hFF] = 8'hEF;
      ram[8'h80] = 8'h12; ram[8'h81] = 8'h34; ram[8'h82] = 8'h56; ram[8'h83] = 8'h78;
      for (int i = 0; i < 256; i++) shadow[i] = ram[i];

      vecs[0] = '{addr: 32'h0000_0000, err: 1'b0, word: 32'h8C01_0004};
      vecs[1] = '{addr: 32'h0000_00FC, err: 1'b0, word: 32'hDEAD_BEEF};
      vecs[2] = '{addr: 32'h0000_01FC, err: 1'b0, word: 32'hDEAD_BEEF};
      vecs[3] = '{addr: 32'h0000_0005, err: 1'b1, word: 32'hDEAD_BEEF};
      vecs[4] = '{addr: 32'hABCD_0080, err: 1'b0, word: 32'h1234_5678};

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst ready", {30'd0, bus.fetch_ready, bus.load_ready}, 32'd0);
      check("rst strobes", {28'd0, bus.mem_re, bus.mem_we, bus.fetch_valid, bus.fetch_err}, 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst addr/data", {16'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
      check("rst instruction", bus.instruction, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle ready", {30'd0, bus.fetch_ready, bus.load_ready}, 32'd3);
      model_instr = 32'd0;

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         run_fetch(vecs[i].addr, vecs[i].err, vecs[i].word, $sformatf("vec%0d", i));
      end

      // Loader and fetch raised together: loader wins, fetch follows
      bus.load_valid = 1'b1; bus.load_addr = 8'h10; bus.load_data = 8'h55;
      bus.fetch_req  = 1'b1; bus.fetch_addr = 32'h10;
      #1;
      check("prio load_ready", 32'(bus.load_ready), 32'd1);
      check("prio fetch_ready", 32'(bus.fetch_ready), 32'd0);
      @(negedge clock);
      check("prio write", {15'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {15'd0, 1'b1, 8'h10, 8'h55});
      check("prio fetch waits", 32'(bus.fetch_ready), 32'd0);
      bus.load_valid = 1'b0;
      shadow[8'h10] = 8'h55;
      @(negedge clock);
      check("prio fetch cycle2", 32'(bus.fetch_ready), 32'd1);
      run_fetch(32'h10, 1'b0, {8'h55, shadow[8'h11], shadow[8'h12], shadow[8'h13]}, "readback");
      check("readback msb", {24'd0, bus.instruction[31:24]}, 32'h55);

      // Reset in cycle 3 of a fetch
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
      nvalid = 0;
      check("rstmid accept", 32'(bus.fetch_ready), 32'd1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         if (bus.fetch_valid) nvalid++;
         bus.fetch_req = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("rstmid strobes", {29'd0, bus.mem_re, bus.mem_we, bus.busy}, 32'd0);
      check("rstmid addr", 32'(bus.mem_addr), 32'd0);
      check("rstmid instruction", bus.instruction, 32'd0);
      check("rstmid ready", {30'd0, bus.fetch_ready, bus.load_ready}, 32'd0);
      repeat (2) begin
         @(negedge clock);
         if (bus.fetch_valid) nvalid++;
      end
      reset = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (bus.fetch_valid) nvalid++;
      end
      check("rstmid no valid", 32'(nvalid), 32'd0);
      model_instr = 32'd0;
      run_fetch(32'h4, 1'b0, model_word(32'h4), "after rst");

      // Back-to-back fetches with fetch_req held
      bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
      check("b2b first accept", 32'(bus.fetch_ready), 32'd1);
      rc = -1; v1 = -1; v2 = -1; bad_busy = 0; w1 = 32'd0; w2 = 32'd0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clock);
         if (bus.fetch_ready && rc < 0) rc = c;
         if (bus.mem_re && !bus.busy) bad_busy++;
         if (bus.fetch_valid) begin
            if (v1 < 0) begin v1 = c; w1 = bus.instruction; end
            else begin v2 = c; w2 = bus.instruction; end
         end
         if (c == 7) check("b2b idle busy", 32'(bus.busy), 32'd0);
         if (c == 1) bus.fetch_addr = 32'h4;
         if (c == 8) bus.fetch_req = 1'b0;
      end
      check("b2b second accept", 32'(rc), 32'd7);
      check("b2b valid cycles", {v1[15:0], v2[15:0]}, {16'd6, 16'd13});
      check("b2b word1", w1, model_word(32'h0));
      check("b2b word2", w2, model_word(32'h4));
      check("b2b busy in read", 32'(bad_busy), 32'd0);
      model_instr = w2;

      // Randomized traffic against the memory model
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            la = 8'($urandom);
            ld = 8'($urandom);
            run_load(la, ld, $sformatf("rnd%0d load", it));
         end else begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (a[1:0] != 2'b00) run_fetch(a, 1'b1, model_instr, $sformatf("rnd%0d fetch", it));
            else                 run_fetch(a, 1'b0, model_word(a), $sformatf("rnd%0d fetch", it));
         end
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
